// File: rtl/display_scanner.sv
// Time-multiplexed scanner for a 4-digit common-anode 7-segment display.
// Steps through the nibbles of a 16-bit value and swaps in new values only at frame boundaries.
module display_scanner #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] value,
  input  logic        blank_lz,
  output logic [3:0]  nibble,
  output logic [3:0]  an_n,
  output logic        blank,
  output logic        frame_start
);

  localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [15:0]   disp;
  logic [15:0]   pend;
  logic          pend_v;
  logic          tick;
  logic          swap;
  logic          zero_3;
  logic          zero_2;
  logic          zero_1;
  logic [3:0]    lz_mask;

  assign tick = (cnt == CNT_MAX);
  assign swap = tick && (idx == 2'd3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      idx         <= '0;
      disp        <= '0;
      pend        <= '0;
      pend_v      <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= swap;
      if (tick) begin
        cnt <= '0;
        idx <= idx + 2'd1;
      end else begin
        cnt <= cnt + CW'(1);
      end
      // A load coinciding with the swap bypasses pend and discards any earlier pending value.
      if (swap) begin
        if (load) begin
          disp   <= value;
          pend_v <= 1'b0;
        end else if (pend_v) begin
          disp   <= pend;
          pend_v <= 1'b0;
        end
      end else if (load) begin
        pend   <= value;
        pend_v <= 1'b1;
      end
    end
  end

  // Digit i is a leading zero when it and every digit to its left are zero; digit 0 never is.
  assign zero_3  = (disp[15:12] == 4'h0);
  assign zero_2  = zero_3 && (disp[11:8] == 4'h0);
  assign zero_1  = zero_2 && (disp[7:4] == 4'h0);
  assign lz_mask = {zero_3, zero_2, zero_1, 1'b0};

  always_comb begin
    blank  = blank_lz && lz_mask[idx];
    nibble = '0;
    an_n   = '1;
    if (!blank) begin
      nibble = disp[{idx, 2'b00} +: 4];
      an_n   = ~(4'b0001 << idx);
    end
  end

endmodule

// File: tb/tb_display_scanner.sv
// Scoreboard bench for display_scanner with SCAN_DIV = 4: the stimulus queues per-cycle
// expected outputs, and a monitor compares them on each falling clock edge.
module tb_display_scanner;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic        blank_lz = 1'b0;
  logic [3:0]  nibble;
  logic [3:0]  an_n;
  logic        blank;
  logic        frame_start;

  display_scanner #(.SCAN_DIV(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .value       (value),
    .blank_lz    (blank_lz),
    .nibble      (nibble),
    .an_n        (an_n),
    .blank       (blank),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    string      name;
    logic [3:0] nib;
    logic [3:0] an;
    logic       bl;
    logic       fs;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fails  = 0;
  int   cyc      = 0;
  int   b        = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops every expectation due at the current cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        n_checks++;
        if (e.cyc != cyc) begin
          n_fails++;
          $display("FAIL %s: expectation for cycle %0d missed (now %0d)", e.name, e.cyc, cyc);
        end else if ({nibble, an_n, blank, frame_start} !== {e.nib, e.an, e.bl, e.fs}) begin
          n_fails++;
          $display("FAIL %s cyc=%0d: got nibble=%h an_n=%b blank=%b fs=%b, want nibble=%h an_n=%b blank=%b fs=%b",
                   e.name, e.cyc - b, nibble, an_n, blank, frame_start, e.nib, e.an, e.bl, e.fs);
        end
      end
    end
  end

  task automatic push_slot(input string name, input int c, input logic [3:0] nib,
                           input logic [3:0] an, input logic bl, input logic fs);
    exp_t e;
    for (int k = 0; k < 4; k++) begin
      e.cyc  = c + k;
      e.name = name;
      e.nib  = nib;
      e.an   = an;
      e.bl   = bl;
      e.fs   = (k == 0) ? fs : 1'b0;
      q.push_back(e);
    end
  endtask

  // nibs/ans packed with digit 0 in [3:0]; blks bit i marks digit i blanked.
  task automatic push_frame(input string name, input int c, input logic [15:0] nibs,
                            input logic [15:0] ans, input logic [3:0] blks, input logic fs);
    for (int d = 0; d < 4; d++)
      push_slot(name, c + 4 * d, nibs[4 * d +: 4], ans[4 * d +: 4], blks[d], (d == 0) ? fs : 1'b0);
  endtask

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load_at(input int c, input logic [15:0] v);
    goto(c);
    load  = 1'b1;
    value = v;
    goto(c + 1);
    load  = 1'b0;
  endtask

  // Asserts reset between clock edges, checks outputs before any edge, then releases.
  task automatic rst_check(input string name);
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({nibble, an_n, blank, frame_start} !== {4'h0, 4'b1110, 1'b0, 1'b0}) begin
      n_fails++;
      $display("FAIL %s: got nibble=%h an_n=%b blank=%b fs=%b, want nibble=0 an_n=1110 blank=0 fs=0",
               name, nibble, an_n, blank, frame_start);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    b   = cyc;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached with %0d expectations pending", q.size());
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    b   = cyc;

    // Reset state, then asynchronous reset mid-slot and an idle frame.
    push_slot("reset_state", b, 4'h0, 4'b1110, 1'b0, 1'b0);
    goto(b + 6);
    rst_check("rst_mid_slot");
    push_frame("idle_frame", b, 16'h0000, 16'h7BDE, 4'b0000, 1'b0);
    goto(b + 16);
    rst_check("rst_before_load");

    // Frames relative to the release above.
    push_frame("hold_old",   b,      16'h0000, 16'h7BDE, 4'b0000, 1'b0);
    push_frame("show_1234",  b + 16, 16'h1234, 16'h7BDE, 4'b0000, 1'b1);
    push_frame("midload_1234", b + 32, 16'h1234, 16'h7BDE, 4'b0000, 1'b1);
    push_frame("show_beef",  b + 48, 16'hBEEF, 16'h7BDE, 4'b0000, 1'b1);
    push_frame("lz_0050",    b + 64, 16'h0050, 16'hFFDE, 4'b1100, 1'b1);
    push_slot("lz_0000_d0",  b + 80, 4'h0, 4'b1110, 1'b0, 1'b1);
    push_slot("lz_0000_d1",  b + 84, 4'h0, 4'b1111, 1'b1, 1'b0);
    push_slot("nolz_d2",     b + 88, 4'h0, 4'b1011, 1'b0, 1'b0);
    push_slot("nolz_d3",     b + 92, 4'h0, 4'b0111, 1'b0, 1'b0);
    push_frame("zero_lit",   b + 96, 16'h0000, 16'h7BDE, 4'b0000, 1'b1);
    push_frame("swap_00c0",  b + 112, 16'h00C0, 16'h7BDE, 4'b0000, 1'b1);
    push_frame("pend_lost",  b + 128, 16'h00C0, 16'h7BDE, 4'b0000, 1'b1);

    load_at(b + 1, 16'h1234);
    load_at(b + 36, 16'hAAAA);
    load_at(b + 40, 16'hBEEF);
    goto(b + 52);
    blank_lz = 1'b1;
    load_at(b + 52, 16'h0050);
    load_at(b + 70, 16'h0000);
    goto(b + 88);
    blank_lz = 1'b0;
    load_at(b + 100, 16'h5555);
    load_at(b + 111, 16'h00C0);
    goto(b + 144);

    // Reset during frame 2 of 0x1234 with a load pending.
    rst_check("rst_pre_frame2");
    push_frame("f0_zero",   b,      16'h0000, 16'h7BDE, 4'b0000, 1'b0);
    push_frame("f1_1234",   b + 16, 16'h1234, 16'h7BDE, 4'b0000, 1'b1);
    push_slot("f2_1234_d0", b + 32, 4'h4, 4'b1110, 1'b0, 1'b1);
    load_at(b + 1, 16'h1234);
    load_at(b + 36, 16'h9999);
    goto(b + 38);
    rst_check("rst_frame2");
    push_frame("after_rst_f0", b,      16'h0000, 16'h7BDE, 4'b0000, 1'b0);
    push_frame("after_rst_f1", b + 16, 16'h0000, 16'h7BDE, 4'b0000, 1'b1);
    goto(b + 32);

    for (int i = 0; i < 50 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      n_checks++;
      n_fails++;
      $display("FAIL drain: %0d expectations never compared, want 0", q.size());
    end
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/display_scanner.md
# display_scanner

Time-multiplexed driver for a 4-digit common-anode 7-segment display. It holds a 16-bit hex value and steps through its four nibbles at a programmable rate. It presents one nibble per time slot to the downstream combinational hex-to-segment decoder, together with the matching active-low digit enable. New values are captured on a load strobe and applied only at a frame boundary, so a displayed frame never tears. Optional leading-zero blanking is supported.

## Interface
- SCAN_DIV, 50000, clock cycles per digit slot; legal range ≥ 2. Prescaler width is $clog2(SCAN_DIV).
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  reset, asynchronous and active-high.
- load  in  1  single-cycle strobe that captures `value`.
- value  in  16  hex value; [3:0] is the rightmost digit (digit 0), [15:12] is digit 3.
- blank_lz  in  1  leading-zero blanking enable; sampled combinationally every cycle.
- nibble  out  4  nibble for the decoder; nibble[3] drives decoder input a (MSB) and nibble[0] drives d.
- an_n  out  4  active-low digit enables; bit i enables digit i.
- blank  out  1  high when the current slot is blanked; the segment gating uses it.
- frame_start  out  1  one-cycle pulse marking the first cycle of digit 0 of each frame.

## Operation
- State registers:
  - cnt: prescaler, 0..SCAN_DIV-1.
  - idx: 2-bit digit index.
  - disp: 16-bit displayed value.
  - pend: 16-bit pending value.
  - pend_v: pending-valid flag.
  - frame_start register.
- Prescaler:
  - cnt increments every cycle.
  - When cnt == SCAN_DIV-1, it is a tick: cnt returns to 0 and idx increments modulo 4, giving digit order 0→1→2→3→0.
- Frame swap happens on a tick with idx == 3, since idx then becomes 0:
  - If load is high in that same cycle, disp takes `value` directly and pend_v clears.
  - Otherwise, if pend_v is set, disp takes pend and pend_v clears.
  - Otherwise disp is unchanged.
- Load outside a swap cycle sets pend to `value` and sets pend_v. When several loads arrive within one frame, the last one wins.
- Leading-zero blanking:
  - Digit i (i = 1..3) is blanked when blank_lz = 1 and disp nibbles i..3 are all zero.
  - Digit 0 is never blanked.
- Outputs are functions of registers (idx, disp) plus blank_lz only; there is no path from load or value to the outputs.
- Unblanked slot: nibble = disp[4·idx+3 : 4·idx]. an_n has only bit idx low. blank = 0.
- Blanked slot: nibble = 0, an_n = 4'b1111, blank = 1.
- frame_start is registered and set on the cycle after a swap tick, so it is high during the first cycle with idx == 0.

## Timing
- Reset values:
  - cnt = 0, idx = 0, disp = 0, pend = 0, pend_v = 0, frame_start = 0.
  - Resulting outputs: nibble = 0, an_n = 4'b1110, blank = 0.
- Reset takes effect immediately when asserted, mid-slot included. The first slot after release lasts a full SCAN_DIV cycles. No frame_start pulse follows reset release.
- Each slot is SCAN_DIV cycles and each frame is 4·SCAN_DIV cycles.
- Worst-case load-to-display latency is 4·SCAN_DIV cycles, measured from the load cycle to the first digit-0 cycle showing the value. A load in the swap cycle shows from the next cycle.
- Slot transitions (an_n, nibble, blank) change on the same edge, so there is no intermediate enable pattern.

## Test plan
All scenarios use SCAN_DIV = 4.

1. Reset: assert rst asynchronously mid-slot → outputs show nibble = 0, an_n = 1110, blank = 0, frame_start = 0 within the same cycle. Hold idle 16 cycles → digit 0 shows 0 and digits 1..3 show 0 with blank_lz = 0.
2. Load 0x1234 one cycle after reset release → the old value (0) is held until cycle 16. From cycle 16, each for 4 cycles: (nibble, an_n) = (4, 1110), (3, 1101), (2, 1011), (1, 0111), repeating. frame_start is high at cycles 16, 32, …
3. With blank_lz = 1:
   - value 0x0050 → digits 3 and 2 give an_n = 1111, blank = 1; digit 1 gives 5/1101; digit 0 gives 0/1110.
   - value 0x0000 → only digit 0 is lit.
   - Drop blank_lz to 0 → all four digits lit on the next cycle.
4. Mid-frame load: while 0x1234 is displayed, load 0xAAAA during digit 1, then 0xBEEF during digit 2 → the current frame still shows 2 and 1. The next frame shows F, E, E, B.
5. Load on the swap cycle (cnt = 3, idx = 3) with 0x00C0 → the next cycle shows digit 0 = 0 and digit 1 = C with pend_v = 0. A pending value from earlier in the frame is discarded.
6. Assert rst during frame 2 of 0x1234 → disp = 0 and idx = 0 immediately. Pending loads are lost, and no value appears until a new load.
